// File: rtl/person_counter.sv
// -----------------------------------------------------------------------------
// person_counter
//
// Purpose:
//   Occupancy counter for a single entry door watched by two IR beam-break
//   sensors. Outer sensor A is on the street side and inner sensor B is on the
//   house side. Each raw beam goes through a 2-FF synchroniser and a debounce
//   filter. A direction FSM runs on the filtered pair {A,B}, recognises
//   complete entry and exit passages, and updates a saturating count.
//   Aborted, reversed or stalled passages never change the count.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   sensor_outer_i  raw outer beam (A), 1 = broken, asynchronous
//   sensor_inner_i  raw inner beam (B), 1 = broken, asynchronous
//   count_clear_i   synchronous clear of the count and the error flag
//   person_count_o  registered occupancy
//   entry_pulse_o   one-cycle pulse, aligned with the count after an entry
//   exit_pulse_o    one-cycle pulse, aligned with the count after an exit
//   error_o         sticky overflow/underflow flag, cleared by count_clear_i
// -----------------------------------------------------------------------------
module person_counter #(
  parameter int COUNT_WIDTH     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sensor_outer_i,
  input  logic                   sensor_inner_i,
  input  logic                   count_clear_i,
  output logic [COUNT_WIDTH-1:0] person_count_o,
  output logic                   entry_pulse_o,
  output logic                   exit_pulse_o,
  output logic                   error_o
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN_A,
    S_EN_AB,
    S_EN_B,
    S_EX_B,
    S_EX_BA,
    S_EX_A,
    S_WAIT_CLEAR
  } state_t;

  // Bit 1 = outer (A), bit 0 = inner (B) throughout.
  logic [1:0]          w_raw;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_filt;
  logic [1:0][DBW-1:0] r_db_cnt;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TOW-1:0]      r_to_cnt;
  logic                w_active;
  logic                w_to_hit;
  logic                w_entry_done;
  logic                w_exit_done;

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_entry_pulse;
  logic                   r_exit_pulse;
  logic                   r_error;

  assign w_raw = {sensor_outer_i, sensor_inner_i};

  // Synchroniser and debounce. The counter only runs while the synchronised
  // level disagrees with the filtered one, so any return to the filtered
  // level (a glitch) starts the qualification over.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt   <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Direction FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction FSM: next state. Pairs not listed for a state hold it.
  always_comb begin
    w_state_nxt  = r_state;
    w_entry_done = 1'b0;
    w_exit_done  = 1'b0;
    w_active     = (r_state != S_IDLE) && (r_state != S_WAIT_CLEAR);
    w_to_hit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        case (r_filt)
          2'b10:   w_state_nxt = S_EN_A;
          2'b01:   w_state_nxt = S_EX_B;
          2'b11:   w_state_nxt = S_WAIT_CLEAR;
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_EN_A: begin
        if (r_filt == 2'b11)      w_state_nxt = S_EN_AB;
        else if (r_filt == 2'b00) w_state_nxt = S_IDLE;
      end
      S_EN_AB: begin
        if (r_filt == 2'b01)      w_state_nxt = S_EN_B;
        else if (r_filt == 2'b10) w_state_nxt = S_EN_A;
      end
      S_EN_B: begin
        if (r_filt == 2'b00) begin
          w_state_nxt  = S_IDLE;
          w_entry_done = 1'b1;
        end else if (r_filt == 2'b11) begin
          w_state_nxt = S_EN_AB;
        end
      end
      S_EX_B: begin
        if (r_filt == 2'b11)      w_state_nxt = S_EX_BA;
        else if (r_filt == 2'b00) w_state_nxt = S_IDLE;
      end
      S_EX_BA: begin
        if (r_filt == 2'b10)      w_state_nxt = S_EX_A;
        else if (r_filt == 2'b01) w_state_nxt = S_EX_B;
      end
      S_EX_A: begin
        if (r_filt == 2'b00) begin
          w_state_nxt = S_IDLE;
          w_exit_done = 1'b1;
        end else if (r_filt == 2'b11) begin
          w_state_nxt = S_EX_BA;
        end
      end
      S_WAIT_CLEAR: begin
        if (r_filt == 2'b00) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A stalled passage is abandoned. A real transition in the same cycle
    // wins, so a completion is never lost to the timer.
    if (w_active && (w_state_nxt == r_state) &&
        (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1))) begin
      w_to_hit    = 1'b1;
      w_state_nxt = (r_filt == 2'b00) ? S_IDLE : S_WAIT_CLEAR;
    end
  end

  // Dwell timer: restarts on every state change, idle outside a passage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (!w_active || (w_state_nxt != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Count, pulses and error flag. Clear wins over a simultaneous completion,
  // which is then dropped together with its pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count       <= '0;
      r_entry_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
      r_error       <= 1'b0;
    end else if (count_clear_i) begin
      r_count       <= '0;
      r_entry_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_entry_pulse <= w_entry_done;
      r_exit_pulse  <= w_exit_done;
      if (w_entry_done) begin
        if (r_count == {COUNT_WIDTH{1'b1}}) r_error <= 1'b1;
        else                                r_count <= r_count + 1'b1;
      end
      if (w_exit_done) begin
        if (r_count == '0) r_error <= 1'b1;
        else               r_count <= r_count - 1'b1;
      end
    end
  end

  assign person_count_o = r_count;
  assign entry_pulse_o  = r_entry_pulse;
  assign exit_pulse_o   = r_exit_pulse;
  assign error_o        = r_error;

endmodule
